data_mem_mmio: RTL and testbench
================================

// Module: data_mem_mmio
// PURPOSE
//  Data-side memory stage downstream of the 3-stage CPU core: consumes the core's stage-3 memory
//  request (MEM_addr/MEM_WR_out/MEM_type/MEM_rd_en/MEM_wr_en) and returns MEM_data.
//  Holds a word-organised data RAM with byte-lane writes plus a small MMIO window
//  (GPIO out, 64-bit cycle timer, compare/interrupt, sticky status).
//  Single clock; loads are zero-wait (combinational read), stores commit on the clock edge.
// PARAMETERS
//  DEPTH      1024          RAM depth in 32-bit words (power of 2); RAM spans 0x0 .. 4*DEPTH-1
//  MMIO_BASE  32'hFFFF0000  base of MMIO window (64-byte aligned)
// PORTS
//  CLK         in   1   clock, rising edge
//  Reset       in   1   asynchronous, active-high reset
//  MEM_addr    in   32  byte address (core's ALU result)
//  MEM_WR_out  in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  MEM_type    in   3   funct3 of access; [1:0]: 00 byte, 01 half, 10 word, 11 reserved
//  MEM_rd_en   in   1   load request this cycle
//  MEM_wr_en   in   1   store request this cycle
//  MEM_data    out  32  raw aligned word at {MEM_addr[31:2],2'b00}; core does lane select/extend
//  gpio_out    out  32  GPIO output register
//  timer_irq   out  1   STATUS.TPEND & STATUS.TEN
//  misalign_err out 1   STATUS.MIS (sticky)
// BEHAVIOUR
//  Reset: gpio_out=0, mtime=0, mtimecmp=32'hFFFFFFFF, STATUS=0 -> timer_irq=0, misalign_err=0.
//   RAM contents are NOT reset. Reset mid-store: store discarded.
//  Decode: RAM if MEM_addr < 4*DEPTH; MMIO if MEM_addr[31:6]==MMIO_BASE[31:6]; else unmapped.
//  Load: MEM_data = selected word when MEM_rd_en=1, else 32'h0; zero latency, same cycle.
//   Unmapped -> 0. Read always returns pre-edge state (no write-through forwarding).
//  Store: commits at rising edge when MEM_wr_en=1 and aligned.
//   byte: lane addr[1:0] gets WR[7:0]; half: lanes {addr[1],0},+1 get WR[15:0]; word: all lanes.
//   Other lanes unchanged. Unmapped stores ignored, no error.
//  Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or type 11 -> store suppressed;
//   STATUS.MIS set on next edge for any misaligned load or store (load data still returned).
//  MEM_rd_en & MEM_wr_en both 1: store performed, MEM_data returns pre-store word.
//  MMIO map (word access only; sub-word MMIO store = ignored, MIS not set):
//   +0x00 GPIO     RW   gpio_out
//   +0x04 MTIME_LO RO   mtime[31:0]
//   +0x08 MTIME_HI RO   mtime[63:32]
//   +0x0C MTIMECMP RW
//   +0x10 STATUS   bit0 TPEND (W1C), bit1 MIS (W1C), bit2 TEN (RW); other bits read 0
//   others in window read 0, writes ignored. Writes to RO regs ignored.
//  mtime: +1 every cycle, 64-bit, wraps 2^64-1 -> 0; not software-writable.
//  TPEND set on edge where mtime[31:0]==mtimecmp (pre-increment value).
//   Same-cycle set and W1C clear: set wins. Same-cycle MTIMECMP write: compare uses old value.
//  MIS same-cycle set and W1C clear: set wins.
//  timer_irq, misalign_err are registered-state derived (no combinational path from inputs).
// TESTING
//  Reset asserted mid-run -> all outputs 0 immediately (async), mtimecmp reads 0xFFFFFFFF after.
//  SW 0x11223344 @0x10, SB 0xAA @0x11, SH 0xBEEF @0x12 -> LW @0x10 returns 0xBEEFAA44.
//  SH @0x21 (type 001) -> word @0x20 unchanged, misalign_err=1; W1C STATUS=0x2 -> misalign_err=0.
//  Write MTIMECMP=50, STATUS=0x4 at cycle 10 -> timer_irq rises after edge where mtime==50;
//   W1C 0x1 -> timer_irq falls next cycle.
//  Read MTIME_LO twice 5 cycles apart -> difference 5; force mtime=2^32-1 -> MTIME_HI increments.
//  LW @0x1234_0000 (unmapped) -> 0; SW there -> no state change; rd_en=0 -> MEM_data=0.

Source files
------------

// File: rtl/data_mem_mmio.sv
// data_mem_mmio: data-side memory stage behind the core's stage-3 request.
// Word-organised RAM with byte-lane stores plus a 64-byte MMIO window
// (GPIO, 64-bit cycle timer, compare/interrupt, sticky status).
// Ports:
//   CLK, Reset            clock (rising edge), asynchronous active-high reset
//   MEM_addr              byte address of the access
//   MEM_WR_out            right-justified store data
//   MEM_type              funct3 of the access, [1:0] = byte/half/word/reserved
//   MEM_rd_en, MEM_wr_en  load / store request this cycle
//   MEM_data              raw aligned word, zero latency, 0 when not loading
//   gpio_out              GPIO output register
//   timer_irq             pending timer interrupt while enabled
//   misalign_err          sticky misaligned-access flag
module data_mem_mmio #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] MEM_addr,
  input  logic [31:0] MEM_WR_out,
  input  logic [2:0]  MEM_type,
  input  logic        MEM_rd_en,
  input  logic        MEM_wr_en,
  output logic [31:0] MEM_data,
  output logic [31:0] gpio_out,
  output logic        timer_irq,
  output logic        misalign_err
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_LIMIT = 32'(4 * DEPTH);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] OFF_GPIO     = 4'h0;
  localparam logic [3:0] OFF_MTIME_LO = 4'h1;
  localparam logic [3:0] OFF_MTIME_HI = 4'h2;
  localparam logic [3:0] OFF_MTIMECMP = 4'h3;
  localparam logic [3:0] OFF_STATUS   = 4'h4;

  logic [31:0] mem [DEPTH];

  logic [63:0] mtime;
  logic [31:0] mtimecmp;
  logic        tpend;
  logic        ten;

  logic [1:0]    size;
  logic [AW-1:0] word_idx;
  logic [3:0]    mmio_off;
  logic          ram_hit;
  logic          mmio_hit;
  logic          misaligned;
  logic          ram_we;
  logic          mmio_we;
  logic          status_we;
  logic          mis_evt;
  logic          cmp_hit;
  logic [3:0]    byte_en;
  logic [31:0]   wr_lanes;
  logic [31:0]   rd_word;
  logic          tpend_n;
  logic          mis_n;
  logic          ten_n;
  logic          unused_type_msb;

  // funct3 bit 2 only selects sign extension, which the core handles
  assign unused_type_msb = MEM_type[2];

  // Address decode and alignment
  always_comb begin
    size       = MEM_type[1:0];
    word_idx   = MEM_addr[AW+1:2];
    mmio_off   = MEM_addr[5:2];
    ram_hit    = (MEM_addr < RAM_LIMIT);
    mmio_hit   = (MEM_addr[31:6] == MMIO_BASE[31:6]);
    misaligned = 1'b0;
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = MEM_addr[0];
      SZ_W:    misaligned = (MEM_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
    // A store landing while Reset is high is dropped
    ram_we    = MEM_wr_en & ram_hit & ~misaligned & ~Reset;
    mmio_we   = MEM_wr_en & mmio_hit & (size == SZ_W) & ~misaligned;
    status_we = mmio_we & (mmio_off == OFF_STATUS);
    mis_evt   = (MEM_rd_en | MEM_wr_en) & misaligned;
    cmp_hit   = (mtime[31:0] == mtimecmp);
  end

  // Byte-lane enables and lane-replicated store data
  always_comb begin
    byte_en  = 4'b1111;
    wr_lanes = MEM_WR_out;
    case (size)
      SZ_B: begin
        byte_en  = 4'b0001 << MEM_addr[1:0];
        wr_lanes = {4{MEM_WR_out[7:0]}};
      end
      SZ_H: begin
        byte_en  = MEM_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{MEM_WR_out[15:0]}};
      end
      default: begin
        byte_en  = 4'b1111;
        wr_lanes = MEM_WR_out;
      end
    endcase
  end

  // Load path: pre-edge state only, no forwarding of a same-cycle store
  always_comb begin
    rd_word = 32'h0;
    if (ram_hit) begin
      rd_word = mem[word_idx];
    end else if (mmio_hit) begin
      case (mmio_off)
        OFF_GPIO:     rd_word = gpio_out;
        OFF_MTIME_LO: rd_word = mtime[31:0];
        OFF_MTIME_HI: rd_word = mtime[63:32];
        OFF_MTIMECMP: rd_word = mtimecmp;
        OFF_STATUS:   rd_word = {29'h0, ten, misalign_err, tpend};
        default:      rd_word = 32'h0;
      endcase
    end
  end

  assign MEM_data = MEM_rd_en ? rd_word : 32'h0;

  // Status next-state: a hardware set beats a same-cycle W1C
  always_comb begin
    tpend_n = tpend;
    mis_n   = misalign_err;
    ten_n   = ten;
    if (status_we) begin
      if (MEM_WR_out[0]) tpend_n = 1'b0;
      if (MEM_WR_out[1]) mis_n   = 1'b0;
      ten_n = MEM_WR_out[2];
    end
    if (cmp_hit) tpend_n = 1'b1;
    if (mis_evt) mis_n   = 1'b1;
  end

  // RAM array: no reset on contents
  always_ff @(posedge CLK) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
  end

  // MMIO registers and free-running timer
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      gpio_out     <= 32'h0;
      mtime        <= 64'h0;
      mtimecmp     <= 32'hFFFF_FFFF;
      tpend        <= 1'b0;
      ten          <= 1'b0;
      misalign_err <= 1'b0;
      timer_irq    <= 1'b0;
    end else begin
      mtime        <= mtime + 64'd1;
      tpend        <= tpend_n;
      ten          <= ten_n;
      misalign_err <= mis_n;
      timer_irq    <= tpend_n & ten_n;
      if (mmio_we && mmio_off == OFF_GPIO)     gpio_out <= MEM_WR_out;
      if (mmio_we && mmio_off == OFF_MTIMECMP) mtimecmp <= MEM_WR_out;
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Scoreboard bench for data_mem_mmio: the driver queues expected values tagged
// with the cycle they must appear in; the monitor compares on each falling edge.
module tb_data_mem_mmio;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  localparam int SIG_DATA = 0;
  localparam int SIG_GPIO = 1;
  localparam int SIG_IRQ  = 2;
  localparam int SIG_MIS  = 3;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] MEM_addr = 32'h0;
  logic [31:0] MEM_WR_out = 32'h0;
  logic [2:0]  MEM_type = 3'b010;
  logic        MEM_rd_en = 1'b0;
  logic        MEM_wr_en = 1'b0;
  logic [31:0] MEM_data;
  logic [31:0] gpio_out;
  logic        timer_irq;
  logic        misalign_err;

  exp_t sbq[$];
  int   cyc = 0;
  int   rel = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   tcmp = 0;

  data_mem_mmio dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .MEM_addr     (MEM_addr),
    .MEM_WR_out   (MEM_WR_out),
    .MEM_type     (MEM_type),
    .MEM_rd_en    (MEM_rd_en),
    .MEM_wr_en    (MEM_wr_en),
    .MEM_data     (MEM_data),
    .gpio_out     (gpio_out),
    .timer_irq    (timer_irq),
    .misalign_err (misalign_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input int sig);
    case (sig)
      SIG_DATA: return MEM_data;
      SIG_GPIO: return gpio_out;
      SIG_IRQ:  return {31'h0, timer_irq};
      default:  return {31'h0, misalign_err};
    endcase
  endfunction

  // Monitor: compare every entry due this cycle, flag any that was skipped
  always @(negedge CLK) begin
    exp_t        keep[$];
    logic [31:0] got;
    keep = {};
    foreach (sbq[i]) begin
      if (sbq[i].cyc == cyc) begin
        got = sample(sbq[i].sig);
        n_tests++;
        if (got !== sbq[i].exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                   sbq[i].name, got, sbq[i].exp, cyc);
        end
      end else if (sbq[i].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: check for cycle %0d never sampled", sbq[i].name, sbq[i].cyc);
      end else begin
        keep.push_back(sbq[i]);
      end
    end
    sbq = keep;
  end

  task automatic chk_at(input int c, input int sig, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = c; e.sig = sig; e.exp = v; e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic chk(input int sig, input logic [31:0] v, input string nm);
    chk_at(cyc, sig, v, nm);
  endtask

  task automatic chk_next(input int sig, input logic [31:0] v, input string nm);
    chk_at(cyc + 1, sig, v, nm);
  endtask

  task automatic op(input logic rd, input logic wr, input logic [2:0] t,
                    input logic [31:0] a, input logic [31:0] d);
    MEM_rd_en  = rd;
    MEM_wr_en  = wr;
    MEM_type   = t;
    MEM_addr   = a;
    MEM_WR_out = d;
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    op(1'b0, 1'b1, 3'b010, a, d);
  endtask

  task automatic lw(input logic [31:0] a);
    op(1'b1, 1'b0, 3'b010, a, 32'h0);
  endtask

  // Advance one cycle and return to an idle bus
  task automatic step();
    @(posedge CLK);
    #1;
    op(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    chk_at(1, SIG_GPIO, 32'h0, "rst_gpio");
    chk_at(1, SIG_IRQ,  32'h0, "rst_irq");
    chk_at(1, SIG_MIS,  32'h0, "rst_mis");
    chk_at(1, SIG_DATA, 32'h0, "rst_data");
    repeat (3) @(posedge CLK);
    #1;
    Reset = 1'b0;
    rel = cyc;

    // Byte-lane merge
    sw(32'h10, 32'h1122_3344); step();
    op(1'b0, 1'b1, 3'b000, 32'h11, 32'h0000_00AA); step();
    op(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000_BEEF); step();
    lw(32'h10); chk(SIG_DATA, 32'hBEEF_AA44, "lane_merge"); step();
    op(1'b1, 1'b1, 3'b010, 32'h10, 32'h5566_7788);
    chk(SIG_DATA, 32'hBEEF_AA44, "rdwr_pre_store"); step();
    lw(32'h10); chk(SIG_DATA, 32'h5566_7788, "rdwr_committed"); step();

    // RAM upper boundary
    sw(32'hFFC, 32'h0BAD_F00D); step();
    lw(32'hFFC); chk(SIG_DATA, 32'h0BAD_F00D, "ram_top_word"); step();
    lw(32'h1000); chk(SIG_DATA, 32'h0, "ram_limit_unmapped"); step();

    // Misaligned accesses
    sw(32'h20, 32'hCAFE_F00D); chk_next(SIG_MIS, 32'h0, "mis_clean"); step();
    op(1'b0, 1'b1, 3'b001, 32'h21, 32'h0000_1234); chk_next(SIG_MIS, 32'h1, "mis_sh_set"); step();
    lw(32'h20); chk(SIG_DATA, 32'hCAFE_F00D, "mis_sh_suppressed"); step();
    sw(MB + 32'h10, 32'h2); chk_next(SIG_MIS, 32'h0, "mis_w1c"); step();
    op(1'b1, 1'b0, 3'b010, 32'h22, 32'h0);
    chk(SIG_DATA, 32'hCAFE_F00D, "mis_load_data");
    chk_next(SIG_MIS, 32'h1, "mis_load_set"); step();
    sw(MB + 32'h10, 32'h2); chk_next(SIG_MIS, 32'h0, "mis_w1c_2"); step();
    op(1'b0, 1'b1, 3'b011, 32'h20, 32'hFFFF_FFFF); chk_next(SIG_MIS, 32'h1, "mis_type11"); step();
    lw(32'h20); chk(SIG_DATA, 32'hCAFE_F00D, "type11_suppressed"); step();
    lw(MB + 32'h10); chk(SIG_DATA, 32'h2, "status_mis_read"); step();
    sw(MB + 32'h10, 32'h2); step();

    // GPIO
    sw(MB, 32'hA5A5_0F0F); chk_next(SIG_GPIO, 32'hA5A5_0F0F, "gpio_write"); step();
    op(1'b0, 1'b1, 3'b000, MB, 32'h0000_00FF);
    chk_next(SIG_GPIO, 32'hA5A5_0F0F, "gpio_sb_ignored");
    chk_next(SIG_MIS, 32'h0, "gpio_sb_no_mis"); step();
    lw(MB); chk(SIG_DATA, 32'hA5A5_0F0F, "gpio_read"); step();

    // Unmapped and idle reads
    lw(32'h1234_0000); chk(SIG_DATA, 32'h0, "unmapped_read"); step();
    sw(32'h1234_0000, 32'h9999_9999); step();
    lw(32'h10); chk(SIG_DATA, 32'h5566_7788, "unmapped_store_no_effect"); step();
    op(1'b0, 1'b0, 3'b010, 32'h10, 32'h0); chk(SIG_DATA, 32'h0, "rd_en_low"); step();
    lw(MB + 32'h14); chk(SIG_DATA, 32'h0, "mmio_hole"); step();

    // Timer read-out
    sw(MB + 32'h4, 32'h0000_1234); step();
    lw(MB + 32'h4); chk(SIG_DATA, 32'(cyc - rel), "mtime_lo_ro"); step();
    repeat (4) step();
    lw(MB + 32'h4); chk(SIG_DATA, 32'(cyc - rel), "mtime_lo_later"); step();
    lw(MB + 32'h8); chk(SIG_DATA, 32'h0, "mtime_hi"); step();
    lw(MB + 32'hC); chk(SIG_DATA, 32'hFFFF_FFFF, "mtimecmp_reset"); step();

    // Compare interrupt
    tcmp = cyc - rel + 20;
    sw(MB + 32'hC, 32'(tcmp)); step();
    sw(MB + 32'h10, 32'h4); step();
    lw(MB + 32'h10); chk(SIG_DATA, 32'h4, "status_ten"); step();
    for (int i = 0; i < 100 && (cyc - rel) < tcmp; i++) step();
    chk(SIG_IRQ, 32'h0, "irq_before_match");
    chk_next(SIG_IRQ, 32'h1, "irq_rise"); step();
    lw(MB + 32'h10); chk(SIG_DATA, 32'h5, "status_pending"); step();
    sw(MB + 32'h10, 32'h0); chk_next(SIG_IRQ, 32'h0, "irq_ten_off"); step();
    lw(MB + 32'h10); chk(SIG_DATA, 32'h1, "tpend_sticky"); step();
    sw(MB + 32'h10, 32'h4); chk_next(SIG_IRQ, 32'h1, "irq_ten_on"); step();
    sw(MB + 32'h10, 32'h5); chk_next(SIG_IRQ, 32'h0, "irq_w1c"); step();

    // MTIMECMP rewritten on the matching cycle: old value still compares
    tcmp = cyc - rel + 3;
    sw(MB + 32'hC, 32'(tcmp)); step();
    step();
    step();
    sw(MB + 32'hC, 32'h0000_7777);
    chk(SIG_IRQ, 32'h0, "cmp_same_cycle_pre");
    chk_next(SIG_IRQ, 32'h1, "cmp_old_value_used"); step();
    lw(MB + 32'hC); chk(SIG_DATA, 32'h0000_7777, "mtimecmp_readback"); step();

    // Asynchronous reset with a store in flight
    op(1'b0, 1'b1, 3'b001, 32'h31, 32'h0); chk_next(SIG_MIS, 32'h1, "mis_before_reset"); step();
    sw(32'h30, 32'h600D_CAFE); step();
    sw(32'h30, 32'hDEAD_DEAD);
    Reset = 1'b1;
    chk(SIG_GPIO, 32'h0, "async_rst_gpio");
    chk(SIG_IRQ,  32'h0, "async_rst_irq");
    chk(SIG_MIS,  32'h0, "async_rst_mis");
    step();
    step();
    Reset = 1'b0;
    rel = cyc;
    lw(MB + 32'hC); chk(SIG_DATA, 32'hFFFF_FFFF, "mtimecmp_after_reset"); step();
    lw(32'h30); chk(SIG_DATA, 32'h600D_CAFE, "store_dropped_in_reset"); step();
    lw(MB + 32'h4); chk(SIG_DATA, 32'(cyc - rel), "mtime_restart"); step();
    lw(MB); chk(SIG_DATA, 32'h0, "gpio_after_reset"); step();

    step();
    step();
    if (sbq.size() != 0) begin
      n_tests += sbq.size();
      n_fail  += sbq.size();
      $display("FAIL drain: %0d checks never sampled", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
